rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 15, maximum number of cycles one grant is held before it is forcibly released; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req  input  4  request vector; bit i is requester i, level-sensitive.
REQ-005 done  input  1  current owner releases the resource; sampled only in GRANT.
REQ-006 gnt  output  4  one-hot grant vector, registered; all zero when no owner.
REQ-007 gnt_id  output  2  binary index of the granted requester, registered; 0 when gnt is zero.
REQ-008 busy  output  1  high exactly when gnt is non-zero.
REQ-009 timeout  output  1  one-cycle pulse on the cycle a grant is forcibly released by the hold limit.

Function
REQ-010 The block SHALL have a two-state FSM: IDLE (no owner) and GRANT (one owner).
REQ-011 It SHALL hold a 2-bit round-robin pointer ptr, the highest-priority index for the next arbitration.
REQ-012 In IDLE with req non-zero, the winner SHALL be the first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-013 On that edge the FSM SHALL enter GRANT, gnt SHALL become one-hot for the winner, gnt_id SHALL become its index, and the hold counter SHALL load 1.
REQ-014 Latency: req sampled high at edge N SHALL give gnt high after edge N; no grant is issued without a request.
REQ-015 In IDLE with req zero, the block SHALL stay in IDLE with all outputs zero and ptr unchanged.
REQ-016 In GRANT, release SHALL occur at the edge where any of these holds: done=1, req[gnt_id]=0, or hold counter equals MAX_HOLD.
REQ-017 On release, the FSM SHALL return to IDLE, gnt/gnt_id/busy SHALL go to zero, and ptr SHALL become gnt_id+1 modulo 4 (3 wraps to 0).
REQ-018 Every release SHALL be followed by at least one IDLE cycle with gnt zero; there is no back-to-back handover.
REQ-019 In GRANT without release, the hold counter SHALL increment by 1 per cycle; it is 4 bits wide and SHALL never exceed MAX_HOLD.
REQ-020 timeout SHALL pulse high for one cycle only when the hold limit alone causes the release.
REQ-021 timeout SHALL stay low when done=1 or the owner's request drop coincides with the limit.
REQ-022 In GRANT, request changes on non-owner bits SHALL NOT affect gnt, gnt_id or ptr.
REQ-023 At most one gnt bit SHALL ever be high.
REQ-024 With all four requests held continuously and done pulsed every grant, grants SHALL rotate 0,1,2,3,0, with none starved.

Reset
REQ-025 While rst is high, the block SHALL immediately, without waiting for a clock edge, force the FSM to IDLE, ptr=0, hold counter=0, and gnt=0, gnt_id=0, busy=0, timeout=0.
REQ-026 Reset asserted mid-GRANT SHALL drop the grant immediately.
REQ-027 After rst deasserts, the first arbitration SHALL start with ptr=0.

Verification
REQ-028 After reset, req=4'b0001 -> gnt=4'b0001, gnt_id=0, busy=1 after one edge; done pulse -> gnt=0 next edge, ptr=1.
REQ-029 ptr=1, req=4'b1001 -> gnt=4'b1000, gnt_id=3; after release, with req=4'b1001 held -> gnt=4'b0001 (ptr wrapped to 0).
REQ-030 req=4'b1111 held, done pulsed once per grant -> gnt_id sequence 0,1,2,3,0 with a one-cycle zero gap between grants.
REQ-031 MAX_HOLD=15, req=4'b0100 held, done low -> gnt=4'b0100 for exactly 15 cycles, then timeout=1 for one cycle with gnt=0, then regrant to 2.
REQ-032 rst asserted between clock edges while gnt=4'b0010 -> gnt=0, busy=0 immediately; after release with req=4'b0110 -> gnt_id=1.
REQ-033 Owner drops req while done=0 -> release on that edge, timeout=0; other requesters' toggles during GRANT leave gnt unchanged.

Source files
------------

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with registered one-hot grant and a hold-time limit
module rr_arbiter4 #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [1:0] ptr, win;
  logic [3:0] hold, rot;
  logic owner_req, at_limit, release_now;
  // Rotate so bit 0 is the highest-priority requester, then pick the first set bit
  assign rot = 4'({req, req} >> ptr);
  assign win = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  assign owner_req = req[gnt_id];
  assign at_limit = hold == 4'(MAX_HOLD);
  assign release_now = done || !owner_req || at_limit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      hold    <= 4'd0;
      gnt     <= 4'd0;
      gnt_id  <= 2'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state  <= GRANT;
          gnt    <= 4'b1 << win;
          gnt_id <= win;
          busy   <= 1'b1;
          hold   <= 4'd1;
        end
      end else if (release_now) begin
        state   <= IDLE;
        gnt     <= 4'd0;
        gnt_id  <= 2'd0;
        busy    <= 1'b0;
        hold    <= 4'd0;
        ptr     <= gnt_id + 2'd1;
        timeout <= at_limit && !done && owner_req;
      end else begin
        hold <= hold + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed self-checking bench for rr_arbiter4
module tb_rr_arbiter4;
  logic clk = 1'b0, rst = 1'b0, done = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic busy, timeout;
  int checks = 0, errors = 0;

  rr_arbiter4 #(.MAX_HOLD(15)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({gnt, gnt_id, busy, timeout} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b id=%0d busy=%b to=%b want all zero", gnt, gnt_id, busy, timeout);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    req = 4'b0001;
    step();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_grant got gnt=%b id=%0d busy=%b want 0001 0 1", gnt, gnt_id, busy);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    req = 4'b1001;
    step();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      errors++;
      $display("FAIL ptr1_grant got gnt=%b id=%0d want 1000 3", gnt, gnt_id);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL ptr_wrap got gnt=%b id=%0d want 0001 0", gnt, gnt_id);
    end
    done = 1'b1;
    req = 4'b0000;
    step();
    done = 1'b0;
    step();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (gnt_id !== exp_id[k] || gnt !== (4'b0001 << exp_id[k])) begin
        errors++;
        $display("FAIL rotation_%0d got gnt=%b id=%0d want id=%0d", k, gnt, gnt_id, exp_id[k]);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      checks++;
      if (gnt !== 4'b0000) begin
        errors++;
        $display("FAIL rotation_gap_%0d got gnt=%b want 0000", k, gnt);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_timeout();
    int bad = 0;
    req = 4'b0100;
    step();
    for (int i = 0; i < 15; i++) begin
      if (gnt !== 4'b0100 || timeout !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_15 got %0d bad cycles want 0", bad);
    end
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse got gnt=%b to=%b want 0000 1", gnt, timeout);
    end
    step();
    checks++;
    if (gnt !== 4'b0100 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_regrant got gnt=%b to=%b want 0100 0", gnt, timeout);
    end
    for (int i = 0; i < 14; i++) step();
    req = 4'b0000;
    step();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL drop_at_limit got gnt=%b to=%b want 0000 0", gnt, timeout);
    end
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b0010;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL pre_reset_grant got gnt=%b want 0010", gnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got gnt=%b busy=%b want 0000 0", gnt, busy);
    end
    rst = 1'b0;
    req = 4'b0110;
    step();
    checks++;
    if (gnt_id !== 2'd1 || gnt !== 4'b0010) begin
      errors++;
      $display("FAIL post_reset_arb got gnt=%b id=%0d want 0010 1", gnt, gnt_id);
    end
  endtask

  task automatic test_owner_drop();
    req = 4'b1011;
    step();
    checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      errors++;
      $display("FAIL other_toggle_a got gnt=%b id=%0d want 0010 1", gnt, gnt_id);
    end
    req = 4'b0011;
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL other_toggle_b got gnt=%b want 0010", gnt);
    end
    req = 4'b0001;
    step();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL owner_drop got gnt=%b to=%b want 0000 0", gnt, timeout);
    end
    step();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      errors++;
      $display("FAIL after_drop got gnt=%b id=%0d want 0001 0", gnt, gnt_id);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_timeout();
    test_reset_mid_grant();
    test_owner_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
